// File: rtl/cordic_acc_scheduler_if.sv
// Bus bundle between the CPU-side Avalon-MM slave, the scheduler and the CORDIC datapath.
// Handshakes:
//   Avalon: a read/write is taken in the first cycle it is asserted with waitreq=0; the master
//   holds address/writedata/strobe while waitreq=1. readdata is meaningful only when read=1 and
//   waitreq=0.
//   Datapath: an operand transfers in every cycle dp_in_valid=1. dp_in_valid is raised only when
//   dp_in_ready=1 and is never raised speculatively. dp_done is a one-cycle pulse per finished
//   operand.
interface cordic_acc_scheduler_if;
  logic        address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitreq;
  logic        dp_in_valid;
  logic [31:0] dp_in_data;
  logic        dp_in_ready;
  logic        dp_done;
  logic [31:0] dp_acc;
  logic        dp_acc_clear;

  modport slave (
    input  address, write, read, writedata, dp_in_ready, dp_done, dp_acc,
    output readdata, waitreq, dp_in_valid, dp_in_data, dp_acc_clear
  );

  modport master (
    output address, write, read, writedata, dp_in_ready, dp_done, dp_acc,
    input  readdata, waitreq, dp_in_valid, dp_in_data, dp_acc_clear
  );
endinterface

// File: rtl/cordic_acc_scheduler.sv
// Operand FIFO, issue/in-flight tracking and drain-before-read/clear sequencer for the CORDIC
// accumulate datapath. Optional stall counter: define CORDIC_SCHED_PERF_EN.
module cordic_acc_scheduler #(
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cordic_acc_scheduler_if.slave  bus,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]    MAX_C   = 8'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRAIN_RD  = 2'd1,
    DRAIN_CLR = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [7:0]      inflight;
  logic            err;

  logic req_wr0, req_wr1, req_rd0, req_rd1;
  logic full, drained, push, issue, done_ok, bad_done;
  logic hold, fsm_wait, acc_rd, acc_clear;
  logic [31:0] status_word;

  // Write wins when the master (illegally) raises both strobes.
  assign req_wr0 = bus.write && !bus.address;
  assign req_wr1 = bus.write &&  bus.address;
  assign req_rd0 = bus.read  && !bus.write && !bus.address;
  assign req_rd1 = bus.read  && !bus.write &&  bus.address;

  assign full     = (fifo_count == DEPTH_C);
  assign drained  = (fifo_count == '0) && (inflight == '0);
  assign push     = req_wr0 && !full;
  assign issue    = (fifo_count != '0) && bus.dp_in_ready && (inflight < MAX_C);
  assign done_ok  = bus.dp_done && (inflight != '0);
  assign bad_done = bus.dp_done && (inflight == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A drain state only completes the request it was entered for; if the master has dropped it,
  // whatever is on the bus now is handled exactly as from IDLE.
  always_comb begin
    state_nxt = state;
    hold      = 1'b0;
    fsm_wait  = 1'b0;
    acc_rd    = 1'b0;
    acc_clear = 1'b0;
    case (state)
      DRAIN_RD:  hold = req_rd1;
      DRAIN_CLR: hold = req_wr1;
      default:   hold = 1'b0;
    endcase
    if (hold) begin
      if (drained) begin
        state_nxt = IDLE;
        acc_rd    = (state == DRAIN_RD);
        acc_clear = (state == DRAIN_CLR);
      end else begin
        fsm_wait  = 1'b1;
      end
    end else begin
      state_nxt = IDLE;
      if (req_wr1) begin
        if (drained) acc_clear = 1'b1;
        else begin
          fsm_wait  = 1'b1;
          state_nxt = DRAIN_CLR;
        end
      end else if (req_rd1) begin
        if (drained) acc_rd = 1'b1;
        else begin
          fsm_wait  = 1'b1;
          state_nxt = DRAIN_RD;
        end
      end
    end
  end

  // Full is judged on the registered count, so a pop in the same cycle does not free space.
  assign bus.waitreq      = fsm_wait || (req_wr0 && full);
  assign bus.dp_in_valid  = issue;
  assign bus.dp_in_data   = mem[rd_ptr];
  assign bus.dp_acc_clear = acc_clear;
  assign dbg_state        = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.writedata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      case ({issue, done_ok})
        2'b10:   inflight <= inflight + 8'd1;
        2'b01:   inflight <= inflight - 8'd1;
        default: inflight <= inflight;
      endcase
      if (bad_done)       err <= 1'b1;
      else if (acc_clear) err <= 1'b0;
    end
  end

`ifdef CORDIC_SCHED_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 stall_cnt <= '0;
    else if (acc_clear)                           stall_cnt <= '0;
    else if (bus.waitreq && (stall_cnt != '1))    stall_cnt <= stall_cnt + 32'd1;
  end

  assign status_word = stall_cnt;
`else
  assign status_word = {err, 15'b0, inflight, 8'(fifo_count)};
`endif

  always_comb begin
    bus.readdata = '0;
    if (acc_rd)       bus.readdata = bus.dp_acc;
    else if (req_rd0) bus.readdata = status_word;
  end

endmodule

// File: tb/tb_cordic_acc_scheduler.sv
// Scoreboard bench for cordic_acc_scheduler: operand queue model, datapath latency model and
// a per-cycle monitor comparing the bus and datapath side against the model.
module tb_cordic_acc_scheduler;

  localparam int DEPTH = 8;
  localparam int MAXI  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  cordic_acc_scheduler_if bus ();

  cordic_acc_scheduler #(.FIFO_DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          pend_q[$];
  int          mi = 0;
  bit          merr = 1'b0;
  logic [31:0] mstall = '0;
  int          ready_mode = 1;
  int          lat_lo = 6;
  int          lat_hi = 8;
  bit          force_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] act, input logic [31:0] exp);
`ifdef CORDIC_SCHED_PERF_EN
    check(name, act, mstall);
`else
    check(name, act, exp);
`endif
  endtask

  // Datapath model: ready pattern, accumulator value and done pulses at the scheduled cycles.
  initial begin
    bus.dp_in_ready = 1'b0;
    bus.dp_done     = 1'b0;
    bus.dp_acc      = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.dp_acc = $urandom;
      case (ready_mode)
        0:       bus.dp_in_ready = 1'b0;
        1:       bus.dp_in_ready = 1'b1;
        default: bus.dp_in_ready = 1'($urandom_range(1, 0));
      endcase
      bus.dp_done = 1'b0;
      if (reset_n) begin
        if (force_done) begin
          bus.dp_done = 1'b1;
          force_done  = 1'b0;
        end else begin
          for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i] <= cyc) begin
              bus.dp_done = 1'b1;
              pend_q.delete(i);
              break;
            end
          end
        end
      end
    end
  end

  // Monitor: predicts every observable output from the model, then advances the model.
  logic        m_wr0, m_wr1, m_rd0, m_rd1, m_drn, m_issue, m_wait;
  logic [31:0] m_status;
  int          m_mi0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      pend_q.delete();
      mi     = 0;
      merr   = 1'b0;
      mstall = '0;
    end else begin
      m_wr0   = bus.write && !bus.address;
      m_wr1   = bus.write &&  bus.address;
      m_rd0   = bus.read && !bus.write && !bus.address;
      m_rd1   = bus.read && !bus.write &&  bus.address;
      m_drn   = (exp_q.size() == 0) && (mi == 0);
      m_issue = (exp_q.size() > 0) && bus.dp_in_ready && (mi < MAXI);
      m_wait  = (m_wr1 || m_rd1) ? !m_drn : (m_wr0 ? (exp_q.size() == DEPTH) : 1'b0);
`ifdef CORDIC_SCHED_PERF_EN
      m_status = mstall;
`else
      m_status = {merr, 15'b0, 8'(mi), 8'(exp_q.size())};
`endif
      check("dp_in_valid", {31'b0, bus.dp_in_valid}, {31'b0, m_issue});
      if (m_issue && bus.dp_in_valid) check("dp_in_data", bus.dp_in_data, exp_q[0]);
      if (bus.write || bus.read) check("waitreq", {31'b0, bus.waitreq}, {31'b0, m_wait});
      check("dp_acc_clear", {31'b0, bus.dp_acc_clear}, {31'b0, m_wr1 && m_drn});
      if (m_rd0) check("rd_status", bus.readdata, m_status);
      if (m_rd1 && m_drn) check("rd_acc", bus.readdata, bus.dp_acc);

      if (m_wr1 && m_drn) mstall = '0;
      else if (m_wait && mstall != 32'hffff_ffff) mstall = mstall + 32'd1;
      m_mi0 = mi;
      if (m_wr1 && m_drn) merr = 1'b0;
      if (bus.dp_done) begin
        if (m_mi0 == 0) merr = 1'b1;
        else            mi = mi - 1;
      end
      if (m_issue) begin
        void'(exp_q.pop_front());
        mi = mi + 1;
        pend_q.push_back(cyc + $urandom_range(lat_hi, lat_lo));
      end
      if (m_wr0 && !m_wait) exp_q.push_back(bus.writedata);
    end
  end

  // Driver tasks: entered and left at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_op(input bit is_wr, input bit addr, input logic [31:0] data,
                        output logic [31:0] rdata);
    int budget;
    budget        = 400;
    rdata         = '0;
    bus.write     = is_wr;
    bus.read      = !is_wr;
    bus.address   = addr;
    bus.writedata = data;
    forever begin
      @(negedge clk);
      if (!bus.waitreq) begin
        rdata = bus.readdata;
        break;
      end
      budget--;
      if (budget == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_op_timeout actual=waitreq_stuck expected=accept (t=%0t)", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget     = 600;
    ready_mode = 1;
    while (!((exp_q.size() == 0) && (mi == 0)) && budget > 0) begin
      idle(1);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=fifo%0d_inflight%0d expected=0_0", exp_q.size(), mi);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          r;
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    bus.address   = 1'b0;
    bus.writedata = '0;
    idle(3);
    reset_n = 1'b1;

    // Reset state
    check("rst_waitreq", {31'b0, bus.waitreq}, 32'd0);
    check("rst_dp_in_valid", {31'b0, bus.dp_in_valid}, 32'd0);
    check("rst_dp_acc_clear", {31'b0, bus.dp_acc_clear}, 32'd0);
    bus_op(1'b0, 1'b0, '0, rd);
    check_status("rst_status", rd, 32'h0000_0000);

    // Single operand: issued next cycle, status shows it in flight
    ready_mode = 1;
    bus_op(1'b1, 1'b0, 32'h437f0000, rd);
    idle(1);
    bus_op(1'b0, 1'b0, '0, rd);
    check_status("status_one_inflight", rd, 32'h0000_0100);
    wait_drain();

    // Accumulator read must wait for two operands
    bus_op(1'b1, 1'b0, 32'h437f0000, rd);
    bus_op(1'b1, 1'b0, 32'h43000000, rd);
    bus_op(1'b0, 1'b1, '0, rd);

    // FIFO full: ninth write held until the first pop
    ready_mode = 0;
    fork
      begin
        for (int i = 0; i < 9; i++) bus_op(1'b1, 1'b0, $urandom, rd);
      end
      begin
        idle(12);
        ready_mode = 1;
      end
    join
    wait_drain();

    // Clear with three in flight waits for the drain
    bus_op(1'b1, 1'b0, $urandom, rd);
    bus_op(1'b1, 1'b0, $urandom, rd);
    bus_op(1'b1, 1'b0, $urandom, rd);
    idle(1);
    bus_op(1'b1, 1'b1, '0, rd);
    bus_op(1'b0, 1'b0, '0, rd);
    check_status("status_after_clear", rd, 32'h0000_0000);

    // Spurious done sets the sticky error; a clear removes it
    force_done = 1'b1;
    idle(2);
    bus_op(1'b0, 1'b0, '0, rd);
    check_status("status_err", rd, 32'h8000_0000);
    bus_op(1'b1, 1'b1, '0, rd);
    bus_op(1'b0, 1'b0, '0, rd);
    check_status("status_err_cleared", rd, 32'h0000_0000);

    // Master abandons a pending clear: no pulse may follow
    bus_op(1'b1, 1'b0, $urandom, rd);
    bus_op(1'b1, 1'b0, $urandom, rd);
    bus.write   = 1'b1;
    bus.address = 1'b1;
    idle(2);
    bus.write   = 1'b0;
    wait_drain();

    // Randomized traffic
    ready_mode = 2;
    lat_lo     = 1;
    lat_hi     = 12;
    repeat (300) begin
      r = $urandom_range(9, 0);
      if (r <= 5)      bus_op(1'b1, 1'b0, $urandom, rd);
      else if (r == 6) bus_op(1'b0, 1'b0, '0, rd);
      else if (r == 7) bus_op(1'b0, 1'b1, '0, rd);
      else if (r == 8) bus_op(1'b1, 1'b1, '0, rd);
      else             idle($urandom_range(3, 0));
    end
    wait_drain();

    // Reset in the middle of an accumulator-read drain
    lat_lo = 10;
    lat_hi = 12;
    bus_op(1'b1, 1'b0, $urandom, rd);
    bus_op(1'b1, 1'b0, $urandom, rd);
    bus.read    = 1'b1;
    bus.address = 1'b1;
    idle(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_drain_waitreq", {31'b0, bus.waitreq}, 32'd0);
    bus.read = 1'b0;
    idle(2);
    reset_n = 1'b1;
    bus_op(1'b0, 1'b0, '0, rd);
    check_status("status_after_reset", rd, 32'h0000_0000);

    wait_drain();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
